// File: rtl/mac_seq_pkg.sv
// Shared types and helpers for the MAC sequencer: state encoding, pipeline
// latency derivation and the drain counter type.
package mac_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StDrain,
    StDone
  } state_t;

  // Drain counter covers pipeline latencies up to 255 cycles.
  localparam int unsigned DRAIN_CNT_W = 8;
  typedef logic [DRAIN_CNT_W-1:0] drain_cnt_t;

  function automatic int unsigned pipe_lat(input int unsigned mult_lat,
                                           input int unsigned add_lat);
    return mult_lat + add_lat;
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Enable-gated shift register tracking result validity through the
// multiplier/adder pipeline; freezes whenever the enable is low.
module valid_delay_line #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sr_q;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          sr_q <= '0;
        end else if (en_i) begin
          sr_q <= d_i;
        end
      end
    end else begin : g_multi
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          sr_q <= '0;
        end else if (en_i) begin
          sr_q <= {sr_q[DEPTH-2:0], d_i};
        end
      end
    end
  endgenerate

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/mac_sequencer.sv
// Sequences one dot-product pass: clears the address generator, issues size
// operand sets, drains the multiplier/adder pipeline and pulses done.
module mac_sequencer
  import mac_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned MULT_LAT   = 1,
  parameter int unsigned ADD_LAT    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                go,
  input  logic [ADDR_WIDTH:0] size,
  input  logic                hold,
  output logic                addr_clr,
  output logic                addr_en,
  output logic                pipe_en,
  output logic                out_valid,
  output logic                busy,
  output logic                done
);

  localparam int unsigned PIPE_LAT = pipe_lat(MULT_LAT, ADD_LAT);
  localparam logic [ADDR_WIDTH:0] SIZE_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam drain_cnt_t DRAIN_LAST = drain_cnt_t'(PIPE_LAT - 1);
  localparam drain_cnt_t DRAIN_ONE = drain_cnt_t'(1);

  state_t              state_q, state_d;
  logic [ADDR_WIDTH:0] size_q;
  logic [ADDR_WIDTH:0] issue_cnt_q;
  drain_cnt_t          drain_cnt_q;
  logic                issue_last;
  logic                drain_last;

  assign issue_last = (issue_cnt_q == (size_q - ONE));
  assign drain_last = (drain_cnt_q == DRAIN_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          state_d = (size == '0) ? StDone : StLoad;
        end
      end
      StLoad:  state_d = StRun;
      StRun: begin
        if (!hold && issue_last) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (!hold && drain_last) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    addr_clr = 1'b0;
    addr_en  = 1'b0;
    pipe_en  = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state_q)
      StIdle:  busy = 1'b0;
      StLoad:  addr_clr = 1'b1;
      StRun: begin
        addr_en = ~hold;
        pipe_en = ~hold;
      end
      StDrain: pipe_en = ~hold;
      StDone:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Size is captured once at acceptance so later changes leave the pass alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_q <= '0;
    end else if (state_q == StIdle && go) begin
      size_q <= (size > SIZE_MAX) ? SIZE_MAX : size;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt_q <= '0;
    end else if (state_q == StLoad) begin
      issue_cnt_q <= '0;
    end else if (state_q == StRun && !hold) begin
      issue_cnt_q <= issue_cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_cnt_q <= '0;
    end else if (state_q != StDrain) begin
      drain_cnt_q <= '0;
    end else if (!hold) begin
      drain_cnt_q <= drain_cnt_q + DRAIN_ONE;
    end
  end

  valid_delay_line #(
    .DEPTH(PIPE_LAT)
  ) u_valid_delay_line (
    .clk_i(clk),
    .rst_i(rst),
    .en_i (pipe_en),
    .d_i  (state_q == StRun),
    .q_o  (out_valid)
  );

endmodule
